rx_block_sync: RTL and testbench

Receive block-alignment controller for the 64B/66B GT channel. Samples the 2-bit sync header and header-valid strobe from the GT RX gearbox, issues single-cycle gearbox slip requests until header alignment is found, then declares and supervises block lock. Sits between the GT channel RX outputs and the PCS descrambler/decoder, and drives the channel's RX gearbox-slip input.

---
 rtl/rx_block_sync.sv | 175 +++++++++++++++++
 tb/tb_rx_block_sync.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_block_sync.sv
// 64B/66B receive block-alignment controller: hunts for sync-header alignment via gearbox slips,
// then declares and supervises block lock. Optional statistics counters under RX_BLOCK_SYNC_STAT_EN.
module rx_block_sync #(
    parameter int unsigned LOCK_CNT  = 64,
    parameter int unsigned BAD_MAX   = 16,
    parameter int unsigned SLIP_WAIT = 32
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_rx_done,
    input  logic [1:0]  i_rx_header,
    input  logic        i_rx_header_valid,
    output logic        o_rx_slipbit,
    output logic        o_block_lock,
    output logic [15:0] o_slip_cnt,
    output logic [15:0] o_lock_loss_cnt
);

    localparam int unsigned MAX_A = (LOCK_CNT > BAD_MAX) ? LOCK_CNT : BAD_MAX;
    localparam int unsigned MAX_P = (MAX_A > SLIP_WAIT) ? MAX_A : SLIP_WAIT;
    localparam int unsigned CW    = $clog2(MAX_P) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HUNT,
        S_SLIP,
        S_WAIT,
        S_LOCK
    } state_t;

    state_t          r_state, w_state_nxt;
    logic            r_done_s1, r_done_s2;
    logic [CW-1:0]   r_good, r_win, r_bad, r_wait;
    logic [CW-1:0]   w_good_nxt, w_win_nxt, w_bad_nxt, w_wait_nxt;
    logic [CW-1:0]   w_win_inc, w_bad_inc;
    logic            w_hdr_ok, w_hdr_bad;
    logic            r_slipbit, r_block_lock;

    // rx_done arrives from the GT reset domain
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_done_s1 <= 1'b0;
            r_done_s2 <= 1'b0;
        end else begin
            r_done_s1 <= i_rx_done;
            r_done_s2 <= r_done_s1;
        end
    end

    assign w_hdr_ok  = i_rx_header_valid & (^i_rx_header);
    assign w_hdr_bad = i_rx_header_valid & ~(^i_rx_header);
    assign w_win_inc = r_win + CW'(1);
    assign w_bad_inc = r_bad + CW'(w_hdr_bad);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= S_IDLE;
            r_good       <= '0;
            r_win        <= '0;
            r_bad        <= '0;
            r_wait       <= '0;
            r_slipbit    <= 1'b0;
            r_block_lock <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_good       <= w_good_nxt;
            r_win        <= w_win_nxt;
            r_bad        <= w_bad_nxt;
            r_wait       <= w_wait_nxt;
            r_slipbit    <= (w_state_nxt == S_SLIP);
            r_block_lock <= (w_state_nxt == S_LOCK);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_good_nxt  = r_good;
        w_win_nxt   = r_win;
        w_bad_nxt   = r_bad;
        w_wait_nxt  = r_wait;
        if (!r_done_s2) begin
            w_state_nxt = S_IDLE;
            w_good_nxt  = '0;
            w_win_nxt   = '0;
            w_bad_nxt   = '0;
            w_wait_nxt  = '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    w_state_nxt = S_HUNT;
                    w_good_nxt  = '0;
                    w_win_nxt   = '0;
                    w_bad_nxt   = '0;
                    w_wait_nxt  = '0;
                end
                S_HUNT: begin
                    if (w_hdr_ok) begin
                        if (r_good == CW'(LOCK_CNT - 1)) begin
                            w_state_nxt = S_LOCK;
                            w_good_nxt  = '0;
                            w_win_nxt   = '0;
                            w_bad_nxt   = '0;
                        end else begin
                            w_good_nxt = r_good + CW'(1);
                        end
                    end else if (w_hdr_bad) begin
                        w_state_nxt = S_SLIP;
                        w_good_nxt  = '0;
                    end
                end
                S_SLIP: begin
                    w_state_nxt = S_WAIT;
                    w_wait_nxt  = '0;
                end
                S_WAIT: begin
                    if (r_wait == CW'(SLIP_WAIT - 1)) begin
                        w_state_nxt = S_HUNT;
                        w_good_nxt  = '0;
                        w_wait_nxt  = '0;
                    end else begin
                        w_wait_nxt = r_wait + CW'(1);
                    end
                end
                S_LOCK: begin
                    // Loss of lock takes priority when the window closes on the BAD_MAX-th error
                    if (i_rx_header_valid) begin
                        if (w_bad_inc == CW'(BAD_MAX)) begin
                            w_state_nxt = S_SLIP;
                            w_win_nxt   = '0;
                            w_bad_nxt   = '0;
                        end else if (w_win_inc == CW'(LOCK_CNT)) begin
                            w_win_nxt = '0;
                            w_bad_nxt = '0;
                        end else begin
                            w_win_nxt = w_win_inc;
                            w_bad_nxt = w_bad_inc;
                        end
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    assign o_rx_slipbit = r_slipbit;
    assign o_block_lock = r_block_lock;

`ifdef RX_BLOCK_SYNC_STAT_EN
    logic [15:0] r_slip_cnt, r_loss_cnt;

    // Saturating statistics, cleared only by reset
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_slip_cnt <= 16'h0000;
            r_loss_cnt <= 16'h0000;
        end else begin
            if ((r_state == S_SLIP) && (r_slip_cnt != 16'hFFFF)) begin
                r_slip_cnt <= r_slip_cnt + 16'd1;
            end
            if ((r_state == S_LOCK) && (w_state_nxt == S_SLIP) && (r_loss_cnt != 16'hFFFF)) begin
                r_loss_cnt <= r_loss_cnt + 16'd1;
            end
        end
    end

    assign o_slip_cnt      = r_slip_cnt;
    assign o_lock_loss_cnt = r_loss_cnt;
`else
    assign o_slip_cnt      = 16'h0000;
    assign o_lock_loss_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_rx_block_sync.sv
// Randomized self-checking bench for rx_block_sync against a behavioural alignment model.
module tb_rx_block_sync;

    localparam int LOCK_CNT  = 64;
    localparam int BAD_MAX   = 16;
    localparam int SLIP_WAIT = 32;

    logic        i_clk;
    logic        i_rst;
    logic        i_rx_done;
    logic [1:0]  i_rx_header;
    logic        i_rx_header_valid;
    logic        o_rx_slipbit;
    logic        o_block_lock;
    logic [15:0] o_slip_cnt;
    logic [15:0] o_lock_loss_cnt;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Behavioural model: mode 0 idle, 1 hunt, 2 slip, 3 wait, 4 lock
    int m_mode, m_good, m_win, m_bad, m_left;
    bit m_d1, m_d2;
    bit e_slip, e_lock;
    int e_slips, e_loss;

    rx_block_sync dut (
        .i_clk             (i_clk),
        .i_rst             (i_rst),
        .i_rx_done         (i_rx_done),
        .i_rx_header       (i_rx_header),
        .i_rx_header_valid (i_rx_header_valid),
        .o_rx_slipbit      (o_rx_slipbit),
        .o_block_lock      (o_block_lock),
        .o_slip_cnt        (o_slip_cnt),
        .o_lock_loss_cnt   (o_lock_loss_cnt)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    task automatic model_step();
        bit done_now;
        bit hdr_ok;
        if (i_rst) begin
            m_mode = 0; m_good = 0; m_win = 0; m_bad = 0; m_left = 0;
            m_d1 = 0; m_d2 = 0; e_slip = 0; e_lock = 0; e_slips = 0; e_loss = 0;
            return;
        end
        done_now = m_d2;
        m_d2 = m_d1;
        m_d1 = i_rx_done;
        hdr_ok = (i_rx_header == 2'b01) || (i_rx_header == 2'b10);
        if (m_mode == 2 && e_slips < 65535) e_slips++;
        if (!done_now) begin
            m_mode = 0; m_good = 0; m_win = 0; m_bad = 0; m_left = 0;
        end else begin
            case (m_mode)
                0: m_mode = 1;
                1: if (i_rx_header_valid) begin
                       if (hdr_ok) begin
                           m_good++;
                           if (m_good == LOCK_CNT) begin m_mode = 4; m_good = 0; m_win = 0; m_bad = 0; end
                       end else begin
                           m_mode = 2; m_good = 0;
                       end
                   end
                2: begin m_mode = 3; m_left = SLIP_WAIT; end
                3: begin
                       m_left--;
                       if (m_left == 0) begin m_mode = 1; m_good = 0; end
                   end
                default: if (i_rx_header_valid) begin
                       m_win++;
                       if (!hdr_ok) m_bad++;
                       if (m_bad == BAD_MAX) begin
                           m_mode = 2; m_win = 0; m_bad = 0;
                           if (e_loss < 65535) e_loss++;
                       end else if (m_win == LOCK_CNT) begin
                           m_win = 0; m_bad = 0;
                       end
                   end
            endcase
        end
        e_slip = (m_mode == 2);
        e_lock = (m_mode == 4);
    endtask

    // Advance one clock, update the model, and compare every output
    task automatic step_and_check();
        logic [15:0] x_slips, x_loss;
        @(posedge i_clk);
        model_step();
        cyc++;
        #1;
`ifdef RX_BLOCK_SYNC_STAT_EN
        x_slips = 16'(e_slips);
        x_loss  = 16'(e_loss);
`else
        x_slips = 16'h0000;
        x_loss  = 16'h0000;
`endif
        total += 4;
        if (o_rx_slipbit !== e_slip) begin
            bad++; $display("FAIL slipbit cyc=%0d got=%b exp=%b", cyc, o_rx_slipbit, e_slip);
        end
        if (o_block_lock !== e_lock) begin
            bad++; $display("FAIL block_lock cyc=%0d got=%b exp=%b", cyc, o_block_lock, e_lock);
        end
        if (o_slip_cnt !== x_slips) begin
            bad++; $display("FAIL slip_cnt cyc=%0d got=%0d exp=%0d", cyc, o_slip_cnt, x_slips);
        end
        if (o_lock_loss_cnt !== x_loss) begin
            bad++; $display("FAIL lock_loss_cnt cyc=%0d got=%0d exp=%0d", cyc, o_lock_loss_cnt, x_loss);
        end
    endtask

    function automatic logic [1:0] rand_valid();
        return ($urandom_range(0, 1) != 0) ? 2'b01 : 2'b10;
    endfunction

    function automatic logic [1:0] rand_invalid();
        return ($urandom_range(0, 1) != 0) ? 2'b00 : 2'b11;
    endfunction

    task automatic test_reset();
        bit seen_slip = 0;
        i_rst = 1'b1; i_rx_done = 1'b0; i_rx_header = 2'b00; i_rx_header_valid = 1'b0;
        #3;
        total++;
        if ({o_rx_slipbit, o_block_lock, o_slip_cnt, o_lock_loss_cnt} !== 34'd0) begin
            bad++; $display("FAIL reset_values got=%h exp=0", {o_rx_slipbit, o_block_lock, o_slip_cnt, o_lock_loss_cnt});
        end
        repeat (3) step_and_check();
        i_rst = 1'b0;
        for (int k = 0; k < 200; k++) begin
            i_rx_header = 2'($urandom_range(0, 3));
            i_rx_header_valid = 1'($urandom_range(0, 1));
            step_and_check();
            if (o_rx_slipbit || o_block_lock) seen_slip = 1;
        end
        total++;
        if (seen_slip) begin
            bad++; $display("FAIL idle_quiet got=activity exp=none");
        end
    endtask

    task automatic test_lock();
        bit seen_slip = 0;
        bit locked = 0;
        i_rx_done = 1'b1;
        i_rx_header = 2'b01;
        for (int k = 0; k < 200 && !locked; k++) begin
            i_rx_header_valid = ((k % 33) != 32);
            step_and_check();
            if (o_rx_slipbit) seen_slip = 1;
            locked = o_block_lock;
        end
        total += 2;
        if (!locked) begin bad++; $display("FAIL lock_acquire got=0 exp=1"); end
        if (seen_slip) begin bad++; $display("FAIL lock_no_slip got=1 exp=0"); end
    endtask

    task automatic test_slip();
        int rises[$];
        bit prev = 0;
        bit locked = 0;
        i_rx_header_valid = 1'b1;
        i_rx_header = 2'b00;
        for (int k = 0; k < 250; k++) begin
            step_and_check();
            if (o_rx_slipbit && !prev) rises.push_back(cyc);
            total++;
            if (o_rx_slipbit && prev) begin bad++; $display("FAIL slip_width cyc=%0d got=2+ exp=1", cyc); end
            prev = o_rx_slipbit;
        end
        total++;
        if (rises.size() < 3) begin bad++; $display("FAIL slip_count got=%0d exp>=3", rises.size()); end
        for (int i = 1; i < rises.size(); i++) begin
            total++;
            if (rises[i] - rises[i-1] != SLIP_WAIT + 2) begin
                bad++; $display("FAIL slip_spacing got=%0d exp=%0d", rises[i] - rises[i-1], SLIP_WAIT + 2);
            end
        end
        i_rx_header = 2'b10;
        for (int k = 0; k < 200 && !locked; k++) begin
            step_and_check();
            locked = o_block_lock;
        end
        total++;
        if (!locked) begin bad++; $display("FAIL relock_after_slip got=0 exp=1"); end
    endtask

    task automatic fill_window(input int n_bad, output bit pos[LOCK_CNT]);
        int placed = 0;
        for (int i = 0; i < LOCK_CNT; i++) pos[i] = 0;
        while (placed < n_bad) begin
            int p = $urandom_range(0, LOCK_CNT - 1);
            if (!pos[p]) begin pos[p] = 1; placed++; end
        end
    endtask

    task automatic test_loss();
        bit pos[LOCK_CNT];
        bit seen_slip = 0;
        bit lost = 0;
        int nbad = 0;
        int loss_before = e_loss;
        i_rx_header_valid = 1'b1;
        fill_window(BAD_MAX - 1, pos);
        for (int i = 0; i < LOCK_CNT; i++) begin
            i_rx_header = pos[i] ? rand_invalid() : rand_valid();
            step_and_check();
            if (o_rx_slipbit || !o_block_lock) seen_slip = 1;
        end
        total++;
        if (seen_slip) begin bad++; $display("FAIL window_15_bad got=lost exp=held"); end
        fill_window(BAD_MAX, pos);
        for (int i = 0; i < LOCK_CNT && !lost; i++) begin
            i_rx_header = pos[i] ? rand_invalid() : rand_valid();
            if (pos[i]) nbad++;
            step_and_check();
            if (nbad == BAD_MAX) begin
                lost = 1;
                total++;
                if (!(o_rx_slipbit === 1'b1 && o_block_lock === 1'b0)) begin
                    bad++; $display("FAIL loss_edge got=slip%b lock%b exp=slip1 lock0", o_rx_slipbit, o_block_lock);
                end
            end
        end
`ifdef RX_BLOCK_SYNC_STAT_EN
        total++;
        if (int'(o_lock_loss_cnt) != loss_before + 1) begin
            bad++; $display("FAIL loss_cnt got=%0d exp=%0d", o_lock_loss_cnt, loss_before + 1);
        end
`endif
    endtask

    task automatic test_done_drop();
        bit locked = 0;
        bit seen_slip = 0;
        i_rx_header_valid = 1'b1;
        i_rx_header = 2'b01;
        for (int k = 0; k < 300 && !locked; k++) begin step_and_check(); locked = o_block_lock; end
        total++;
        if (!locked) begin bad++; $display("FAIL pre_drop_lock got=0 exp=1"); end
        i_rx_done = 1'b0;
        for (int k = 0; k < 3; k++) begin step_and_check(); if (o_rx_slipbit) seen_slip = 1; end
        total += 2;
        if (o_block_lock !== 1'b0) begin bad++; $display("FAIL drop_unlock got=%b exp=0", o_block_lock); end
        if (seen_slip) begin bad++; $display("FAIL drop_no_slip got=1 exp=0"); end
        repeat (5) step_and_check();
        i_rx_done = 1'b1;
        locked = 0;
        for (int k = 0; k < 100 && !locked; k++) begin step_and_check(); locked = o_block_lock; end
        total++;
        if (!locked) begin bad++; $display("FAIL drop_relock got=0 exp=1"); end
    endtask

    task automatic test_midrst();
        bit hit = 0;
        i_rx_header_valid = 1'b1;
        i_rx_header = 2'b11;
        for (int k = 0; k < 100 && !hit; k++) begin step_and_check(); hit = o_rx_slipbit; end
        total++;
        if (!hit) begin bad++; $display("FAIL midrst_slip_seen got=0 exp=1"); end
        #2 i_rst = 1'b1;
        #1;
        total++;
        if ({o_rx_slipbit, o_block_lock, o_slip_cnt, o_lock_loss_cnt} !== 34'd0) begin
            bad++; $display("FAIL midrst_clear got=%h exp=0", {o_rx_slipbit, o_block_lock, o_slip_cnt, o_lock_loss_cnt});
        end
        repeat (2) step_and_check();
        i_rst = 1'b0;
    endtask

    task automatic test_random();
        int p_bad;
        for (int blk = 0; blk < 16; blk++) begin
            p_bad = (blk % 4 == 0) ? 0 : (blk % 4 == 1) ? 3 : (blk % 4 == 2) ? 25 : 60;
            for (int k = 0; k < 200; k++) begin
                i_rx_header_valid = ($urandom_range(0, 99) < 90);
                i_rx_header = ($urandom_range(0, 99) < p_bad) ? rand_invalid() : rand_valid();
                if ($urandom_range(0, 399) == 0) i_rx_done = ~i_rx_done;
                else if (!i_rx_done && $urandom_range(0, 9) == 0) i_rx_done = 1'b1;
                step_and_check();
            end
        end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_slip();
        test_loss();
        test_done_drop();
        test_midrst();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
